bit_serial_alu_seq: RTL and testbench

//  Word-level sequencer that drives the existing 1-bit ALU one bit per cycle, LSB first.

---
 rtl/bit_serial_alu_seq.sv | 171 +++++++++++++++++
 tb/tb_bit_serial_alu_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_seq.sv
// Word-level sequencer driving a combinational 1-bit ALU, LSB first, one bit per cycle.
// Optional signed-overflow flag built only when BSALU_OVERFLOW_EN is defined.
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             a_gt_b,
  output logic             illegal,
  output logic             ovf,
  output logic [2:0]       alu_opcode,
  output logic             alu_in1,
  output logic             alu_in2,
  output logic             alu_cin,
  input  logic             alu_out,
  input  logic             alu_cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_LAST = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             zero_q;
  logic             gt_q;
  logic             illegal_q;
  logic             done_q;
  logic             busy_q;

  logic             arith;
  logic             last_bit;
  logic             carry_d;
  logic             gt_d;
  logic [WIDTH-1:0] result_d;

  // Per-bit next values from the current operand bits and the ALU response
  always_comb begin
    arith    = (op_q == OP_ADD) || (op_q == OP_SUB);
    last_bit = (cnt_q == CW'(WIDTH - 1));
    carry_d  = arith ? alu_cout : 1'b0;
    result_d = {alu_out, result_q[WIDTH-1:1]};
    gt_d     = gt_q;
    if (a_q[0] && !b_q[0]) gt_d = 1'b1;
    else if (!a_q[0] && b_q[0]) gt_d = 1'b0;
  end

`ifdef BSALU_OVERFLOW_EN
  logic ovf_q;
  // Signed overflow: carry (or borrow) into the MSB differs from the one out of it
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN && last_bit) begin
      ovf_q <= arith && (carry_q ^ alu_cout);
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      gt_q      <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q      <= opcode;
            cnt_q     <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            gt_q      <= 1'b0;
            busy_q    <= 1'b1;
            if (opcode <= OP_LAST) begin
              a_q       <= a;
              b_q       <= b;
              carry_q   <= (opcode == OP_ADD) ? cin : 1'b0;
              zero_q    <= 1'b0;
              illegal_q <= 1'b0;
              state_q   <= S_RUN;
            end else begin
              a_q       <= '0;
              b_q       <= '0;
              carry_q   <= 1'b0;
              zero_q    <= 1'b1;
              illegal_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          result_q <= result_d;
          gt_q     <= gt_d;
          if (last_bit) begin
            // Final carry moves to cout; chain register returns to 0 for idle drive
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= carry_d;
            zero_q  <= (result_d == '0);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            carry_q <= carry_d;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign cout       = cout_q;
  assign zero       = zero_q;
  assign a_gt_b     = gt_q;
  assign illegal    = illegal_q;
  assign alu_opcode = op_q;
  assign alu_in1    = a_q[0];
  assign alu_in2    = b_q[0];
  assign alu_cin    = carry_q;

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq (WIDTH=8) with a behavioural 1-bit ALU attached.
module tb_bit_serial_alu_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         a_gt_b;
  logic         illegal;
  logic         ovf;
  logic [2:0]   alu_opcode;
  logic         alu_in1;
  logic         alu_in2;
  logic         alu_cin;
  logic         alu_out;
  logic         alu_cout;

  int n_cmp = 0;
  int n_err = 0;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .a_gt_b(a_gt_b),
    .illegal(illegal), .ovf(ovf), .alu_opcode(alu_opcode), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  // Combinational 1-bit ALU; SUB computes in1 - in2 - borrow
  always_comb begin
    alu_out  = 1'b0;
    alu_cout = 1'b0;
    case (alu_opcode)
      3'd0: begin
        alu_out  = alu_in1 ^ alu_in2 ^ alu_cin;
        alu_cout = (alu_in1 & alu_in2) | (alu_cin & (alu_in1 ^ alu_in2));
      end
      3'd1: begin
        alu_out  = alu_in1 ^ alu_in2 ^ alu_cin;
        alu_cout = (~alu_in1 & alu_in2) | (~(alu_in1 ^ alu_in2) & alu_cin);
      end
      3'd2: alu_out = alu_in1 & alu_in2;
      3'd3: alu_out = alu_in1 | alu_in2;
      3'd4: alu_out = ~(alu_in1 & alu_in2);
      3'd5: alu_out = ~(alu_in1 | alu_in2);
      default: ;
    endcase
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         gt;
    logic         ill;
    logic         ovf;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise start for one cycle, then count edges until done (0 if it never comes)
  task automatic issue(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vcin, output int lat);
    lat = 0;
    opcode = op; a = va; b = vb; cin = vcin; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic exp_ovf;
    logic [W-1:0] held;

    vecs[0]  = '{3'd0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd1, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd5, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd3, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd4, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{3'd1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{3'd1, 8'h03, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'd6, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'd7, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; opcode = 3'd0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {19'd0, busy, done, result, cout, zero, a_gt_b, illegal, ovf},
        32'd0);
    chk("reset_alu_drive", {26'd0, alu_opcode, alu_in1, alu_in2, alu_cin}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
`ifdef BSALU_OVERFLOW_EN
      exp_ovf = vecs[i].ovf;
`else
      exp_ovf = 1'b0;
`endif
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), vecs[i].ill ? 32'd1 : 32'(W + 1));
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
      chk($sformatf("v%0d_a_gt_b", i), 32'(a_gt_b), 32'(vecs[i].gt));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(exp_ovf));
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_flags", i), {30'd0, busy, done}, 32'd0);
      chk($sformatf("v%0d_hold", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d_idle_drive", i), {29'd0, alu_in1, alu_in2, alu_cin}, 32'd0);
    end

    // start (with an illegal opcode) pulsed mid-RUN must be ignored, not queued
    lat = 0;
    opcode = 3'd0; a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 2) chk("chain_cin_bit1", 32'(alu_cin), 32'd1);
      if (k == 3) begin
        start = 1'b1; opcode = 3'd6;
      end
      if (k == 4) begin
        start = 1'b0; opcode = 3'd0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("ign_latency", 32'(lat), 32'(W + 1));
    chk("ign_result", 32'(result), 32'h02);
    chk("ign_illegal", 32'(illegal), 32'd0);
    held = result;
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("ign_no_queue", 32'(ndone), 32'd0);
    chk("ign_hold", 32'(result), 32'(held));

    // Reset during bit 4 of an ADD aborts with no done pulse
    opcode = 3'd0; a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_run_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_outputs", {19'd0, busy, done, result, cout, zero, a_gt_b, illegal, ovf},
        32'd0);
    chk("abort_alu_drive", {26'd0, alu_opcode, alu_in1, alu_in2, alu_cin}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    // Fresh operation after the abort
    issue(3'd0, 8'h01, 8'h02, 1'b1, lat);
    chk("post_abort_latency", 32'(lat), 32'(W + 1));
    chk("post_abort_result", 32'(result), 32'h04);
    chk("post_abort_gt", 32'(a_gt_b), 32'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
